// File: rtl/alu_issue.sv
// alu_issue: decodes one MIPS ALU instruction per handshake into ALU operands
// and write-back control, then buffers the result in a 2-entry FIFO.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  aluc,
  output logic [4:0]  dst,
  output logic        wen,
  output logic        trap_ovf,
  output logic        illegal
);

  localparam int unsigned DEPTH = 2;

  typedef enum logic [3:0] {
    ALU_ADDU = 4'b0000,
    ALU_SUBU = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_LUI  = 4'b1000,
    ALU_SLTU = 4'b1010,
    ALU_SLT  = 4'b1011,
    ALU_SRA  = 4'b1100,
    ALU_SRL  = 4'b1101,
    ALU_SLL  = 4'b1110
  } aluc_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    aluc_e       aluc;
    logic [4:0]  dst;
    logic        wen;
    logic        trap_ovf;
    logic        illegal;
  } entry_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sx;
  logic [31:0] imm_zx;
  logic        legal;
  entry_t      dec;

  // Register specifiers for rs arrive pre-read as rs_val
  logic unused_rs_field;
  assign unused_rs_field = ^instr[25:21];

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm_sx = {{16{instr[15]}}, instr[15:0]};
  assign imm_zx = {16'h0000, instr[15:0]};

  // Combinational decode of the presented instruction into a FIFO entry
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    if (opcode == 6'b000000) begin
      dec.dst = instr[15:11];
      dec.a   = rs_val;
      dec.b   = rt_val;
      case (funct)
        6'b100000: begin dec.aluc = ALU_ADD; dec.trap_ovf = 1'b1; end
        6'b100001: dec.aluc = ALU_ADDU;
        6'b100010: begin dec.aluc = ALU_SUB; dec.trap_ovf = 1'b1; end
        6'b100011: dec.aluc = ALU_SUBU;
        6'b100100: dec.aluc = ALU_AND;
        6'b100101: dec.aluc = ALU_OR;
        6'b100110: dec.aluc = ALU_XOR;
        6'b100111: dec.aluc = ALU_NOR;
        6'b101010: dec.aluc = ALU_SLT;
        6'b101011: dec.aluc = ALU_SLTU;
        6'b000000: begin dec.aluc = ALU_SLL; dec.a = {27'b0, instr[10:6]}; end
        6'b000010: begin dec.aluc = ALU_SRL; dec.a = {27'b0, instr[10:6]}; end
        6'b000011: begin dec.aluc = ALU_SRA; dec.a = {27'b0, instr[10:6]}; end
        // Variable shifts: ALU shifts by the full a, so mask to 5 bits here
        6'b000100: begin dec.aluc = ALU_SLL; dec.a = {27'b0, rs_val[4:0]}; end
        6'b000110: begin dec.aluc = ALU_SRL; dec.a = {27'b0, rs_val[4:0]}; end
        6'b000111: begin dec.aluc = ALU_SRA; dec.a = {27'b0, rs_val[4:0]}; end
        default:   legal = 1'b0;
      endcase
    end else begin
      dec.dst = instr[20:16];
      dec.a   = rs_val;
      case (opcode)
        6'b001000: begin dec.aluc = ALU_ADD; dec.b = imm_sx; dec.trap_ovf = 1'b1; end
        6'b001001: begin dec.aluc = ALU_ADDU; dec.b = imm_sx; end
        6'b001010: begin dec.aluc = ALU_SLT;  dec.b = imm_sx; end
        6'b001011: begin dec.aluc = ALU_SLTU; dec.b = imm_sx; end
        6'b001100: begin dec.aluc = ALU_AND;  dec.b = imm_zx; end
        6'b001101: begin dec.aluc = ALU_OR;   dec.b = imm_zx; end
        6'b001110: begin dec.aluc = ALU_XOR;  dec.b = imm_zx; end
        6'b001111: begin dec.aluc = ALU_LUI;  dec.b = imm_zx; dec.a = '0; end
        default:   legal = 1'b0;
      endcase
    end
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    dec.wen = legal && (dec.dst != 5'd0);
  end

  entry_t     mem_q [DEPTH];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;
  entry_t     head;

  assign push = in_valid && in_ready_q && !flush;
  assign pop  = (count_q != 2'd0) && out_ready && !flush;

  // FIFO pointer/occupancy next-state; in_ready is precomputed from count_d
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    in_ready_d = (count_d != 2'd2);
  end

  // FIFO state and storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) mem_q[wr_ptr_q] <= dec;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign a         = head.a;
  assign b         = head.b;
  assign aluc      = head.aluc;
  assign dst       = head.dst;
  assign wen       = head.wen;
  assign trap_ovf  = head.trap_ovf;
  assign illegal   = head.illegal;

endmodule
